// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] i_tx_data;
    logic              i_tx_req;
    logic              o_tx_busy;
    logic              o_tx_done;
    logic              o_tx_err;

    // Requester side: drives the byte and request, watches status.
    modport master (
        output i_tx_data,
        output i_tx_req,
        input  o_tx_busy,
        input  o_tx_done,
        input  o_tx_err
    );

    // Transmitter side.
    modport slave (
        input  i_tx_data,
        input  i_tx_req,
        output o_tx_busy,
        output o_tx_done,
        output o_tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Runs request-to-send (clock inhibit, start bit), shifts data/parity/stop on
// device falling edges, and guards every wait with a watchdog.
// Optional feature macro PS2_TX_ACK_CHECK_EN: sample the device ACK and wait
// for both lines idle before reporting done. Without it, done is reported on
// the falling edge that follows the stop bit.
module ps2_host_tx #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_US  = 15000
) (
    input  logic         CLK_50M,
    input  logic         RST_N,
    input  logic         PS2_CLK,
    input  logic         PS2_DATA,
    output logic         PS2_CLK_OE,
    output logic         PS2_DATA_OE,
    ps2_host_tx_if.slave tx
);
    localparam int unsigned CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
    localparam int unsigned TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
    localparam int unsigned INH_W       = $clog2(INHIBIT_CYC + 1);
    localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FRAME_W     = 10;
    localparam int unsigned BIT_W       = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_ERR
    } state_t;

    state_t             state_q;
    logic               clk_meta_q;
    logic               clk_sync_q;
    logic               clk_prev_q;
    logic               data_meta_q;
    logic               data_sync_q;
    logic               clk_oe_q;
    logic               data_oe_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [FRAME_W-1:0] shift_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [INH_W-1:0]   inh_cnt_q;
    logic [TO_W-1:0]    wdog_q;
    logic               dev_fall_c;
    logic               wdog_expired_c;

    // Two-stage synchronizers for both pins plus a delayed clock copy for edge detect.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= PS2_CLK;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= PS2_DATA;
            data_sync_q <= data_meta_q;
        end
    end

    assign dev_fall_c     = clk_prev_q & ~clk_sync_q;
    assign wdog_expired_c = (wdog_q == TO_W'(TIMEOUT_CYC - 1));

`ifndef PS2_TX_ACK_CHECK_EN
    // Synchronized data is only consumed by the ACK/idle checks.
    logic data_sync_unused_c;
    assign data_sync_unused_c = data_sync_q;
`endif

    // Transmit sequencer: request-to-send, bit shifting, ACK and watchdog.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            wdog_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (tx.i_tx_req) begin
                        shift_q   <= {1'b1, ~^tx.i_tx_data, tx.i_tx_data};
                        inh_cnt_q <= '0;
                        clk_oe_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (inh_cnt_q == INH_W'(INHIBIT_CYC - 1)) begin
                        // Start bit goes out on the same edge the clock is released.
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b1;
                        state_q   <= ST_START;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + INH_W'(1);
                    end
                end

                ST_START: begin
                    wdog_q    <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (dev_fall_c) begin
                        wdog_q <= '0;
                        if (bit_cnt_q == BIT_W'(FRAME_W)) begin
`ifdef PS2_TX_ACK_CHECK_EN
                            state_q <= ST_ACK;
`else
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
`endif
                        end else begin
                            data_oe_q <= ~shift_q[0];
                            shift_q   <= {1'b0, shift_q[FRAME_W-1:1]};
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else if (wdog_expired_c) begin
                        state_q <= ST_ERR;
                    end else begin
                        wdog_q <= wdog_q + TO_W'(1);
                    end
                end

`ifdef PS2_TX_ACK_CHECK_EN
                ST_ACK: begin
                    if (dev_fall_c) begin
                        wdog_q  <= '0;
                        state_q <= data_sync_q ? ST_ERR : ST_WAIT_IDLE;
                    end else if (wdog_expired_c) begin
                        state_q <= ST_ERR;
                    end else begin
                        wdog_q <= wdog_q + TO_W'(1);
                    end
                end

                ST_WAIT_IDLE: begin
                    if (clk_sync_q && data_sync_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (dev_fall_c) begin
                        wdog_q <= '0;
                    end else if (wdog_expired_c) begin
                        state_q <= ST_ERR;
                    end else begin
                        wdog_q <= wdog_q + TO_W'(1);
                    end
                end
`endif

                ST_ERR: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    err_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign PS2_CLK_OE   = clk_oe_q;
    assign PS2_DATA_OE  = data_oe_q;
    assign tx.o_tx_busy = busy_q;
    assign tx.o_tx_done = done_q;
    assign tx.o_tx_err  = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a simple PS/2 device model on open-drain lines.
module tb_ps2_host_tx;
    localparam int unsigned CLK_FREQ_HZ = 1_000_000;
    localparam int unsigned INHIBIT_US  = 100;
    localparam int unsigned TIMEOUT_US  = 2000;
    localparam int INHIBIT_CYC = 100;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HALF        = 20;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic clk_oe;
    logic data_oe;
    logic ps2_clk;
    logic ps2_data;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int wide_cnt  = 0;
    int b2b_cnt   = 0;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    ps2_host_tx_if tx_if ();

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk  = dev_clk  & ~clk_oe;
    assign ps2_data = dev_data & ~data_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .CLK_50M    (clk),
        .RST_N      (rst_n),
        .PS2_CLK    (ps2_clk),
        .PS2_DATA   (ps2_data),
        .PS2_CLK_OE (clk_oe),
        .PS2_DATA_OE(data_oe),
        .tx         (tx_if)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts done/err pulses, overlaps, stretched pulses and re-accepts.
    always @(negedge clk) begin
        if (tx_if.o_tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_if.o_tx_err === 1'b1) err_cnt <= err_cnt + 1;
        if (tx_if.o_tx_done === 1'b1 && tx_if.o_tx_err === 1'b1) both_cnt <= both_cnt + 1;
        if ((tx_if.o_tx_done === 1'b1 && prev_done) || (tx_if.o_tx_err === 1'b1 && prev_err))
            wide_cnt <= wide_cnt + 1;
        if (prev_done && clk_oe === 1'b1) b2b_cnt <= b2b_cnt + 1;
        prev_done <= (tx_if.o_tx_done === 1'b1);
        prev_err  <= (tx_if.o_tx_err === 1'b1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [7:0] b, input bit hold);
        tx_if.i_tx_data = b;
        tx_if.i_tx_req  = 1'b1;
        cyc(1);
        if (!hold) tx_if.i_tx_req = 1'b0;
    endtask

    // Counts samples with the clock inhibited; returns the data OE seen at release.
    task automatic wait_release(output int hi, output logic d_oe);
        hi = 0;
        while (clk_oe === 1'b1 && hi < 4 * INHIBIT_CYC) begin
            hi++;
            cyc(1);
        end
        d_oe = data_oe;
    endtask

    // Device clocks out a frame; bits[0] = start, [8:1] data, [9] parity, [10] stop.
    task automatic device_clock(input bit ack_low, input int repulse_at, input int abort_at,
                                output logic [10:0] bits);
        bits = '0;
        cyc(HALF);
        bits[0] = ps2_data;
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            if (i == repulse_at) begin
                tx_if.i_tx_data = 8'h55;
                tx_if.i_tx_req  = 1'b1;
                cyc(4);
                tx_if.i_tx_req  = 1'b0;
                cyc(HALF - 4);
            end else begin
                cyc(HALF);
            end
            if (i <= 10) bits[i] = ps2_data;
            if (i == abort_at) return;
            dev_clk = 1'b1;
            cyc(HALF);
        end
        dev_data = ack_low ? 1'b0 : 1'b1;
        cyc(HALF / 2);
        dev_clk = 1'b0;
        cyc(HALF);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(3);
        checks++;
        if ({clk_oe, data_oe, tx_if.o_tx_busy, tx_if.o_tx_done, tx_if.o_tx_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=00000",
                     {clk_oe, data_oe, tx_if.o_tx_busy, tx_if.o_tx_done, tx_if.o_tx_err});
        end
        rst_n = 1'b1;
        cyc(3);
    endtask

    task automatic test_send_byte(input string name, input logic [7:0] b, input logic par,
                                  input int repulse_at);
        logic [10:0] exp;
        logic [10:0] got;
        int hi;
        logic doe;
        int d0;
        int e0;
        exp = {1'b1, par, b, 1'b0};
        d0 = done_cnt;
        e0 = err_cnt;
        issue_req(b, 1'b0);
        checks++;
        if ({clk_oe, tx_if.o_tx_busy} !== 2'b11) begin
            failures++;
            $display("FAIL %s_accept clk_oe,busy got=%b exp=11", name, {clk_oe, tx_if.o_tx_busy});
        end
        wait_release(hi, doe);
        checks++;
        if (hi !== INHIBIT_CYC) begin
            failures++;
            $display("FAIL %s_inhibit_len got=%0d exp=%0d", name, hi, INHIBIT_CYC);
        end
        checks++;
        if (doe !== 1'b1) begin
            failures++;
            $display("FAIL %s_start_bit data_oe at release got=%b exp=1", name, doe);
        end
        device_clock(1'b1, repulse_at, 0, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s_frame_bits got=%b exp=%b", name, got, exp);
        end
        cyc(30);
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            failures++;
            $display("FAIL %s_status done=%0d err=%0d exp done=1 err=0", name, done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({clk_oe, data_oe, tx_if.o_tx_busy} !== 3'b0) begin
            failures++;
            $display("FAIL %s_idle oe/busy got=%b exp=000", name, {clk_oe, data_oe, tx_if.o_tx_busy});
        end
    endtask

    task automatic test_timeout();
        int hi;
        logic doe;
        int n;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        issue_req(8'hF4, 1'b0);
        wait_release(hi, doe);
        n = 0;
        while (tx_if.o_tx_err !== 1'b1 && n < 3 * TIMEOUT_CYC) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n < TIMEOUT_CYC || n > TIMEOUT_CYC + 3) begin
            failures++;
            $display("FAIL timeout_latency got=%0d exp=%0d..%0d", n, TIMEOUT_CYC, TIMEOUT_CYC + 3);
        end
        checks++;
        if ({clk_oe, data_oe} !== 2'b00) begin
            failures++;
            $display("FAIL timeout_release oe got=%b exp=00", {clk_oe, data_oe});
        end
        cyc(2);
        checks++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0 || tx_if.o_tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_status err=%0d done=%0d busy=%b exp err=1 done=0 busy=0",
                     err_cnt - e0, done_cnt - d0, tx_if.o_tx_busy);
        end
    endtask

    task automatic test_ack_high();
        logic [10:0] got;
        int hi;
        logic doe;
        int d0;
        int e0;
        int exp_done;
        int exp_err;
`ifdef PS2_TX_ACK_CHECK_EN
        exp_done = 0;
        exp_err  = 1;
`else
        exp_done = 1;
        exp_err  = 0;
`endif
        d0 = done_cnt;
        e0 = err_cnt;
        issue_req(8'hA5, 1'b0);
        wait_release(hi, doe);
        device_clock(1'b0, 0, 0, got);
        checks++;
        if (got !== 11'b1_1_10100101_0) begin
            failures++;
            $display("FAIL ack_high_frame got=%b exp=%b", got, 11'b1_1_10100101_0);
        end
        cyc(30);
        checks++;
        if (done_cnt - d0 !== exp_done || err_cnt - e0 !== exp_err) begin
            failures++;
            $display("FAIL ack_high_status done=%0d err=%0d exp done=%0d err=%0d",
                     done_cnt - d0, err_cnt - e0, exp_done, exp_err);
        end
        checks++;
        if ({clk_oe, data_oe, tx_if.o_tx_busy} !== 3'b0) begin
            failures++;
            $display("FAIL ack_high_idle got=%b exp=000", {clk_oe, data_oe, tx_if.o_tx_busy});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] got;
        int hi;
        logic doe;
        issue_req(8'hED, 1'b0);
        wait_release(hi, doe);
        device_clock(1'b1, 0, 4, got);
        checks++;
        if (got[4:0] !== 5'b11010) begin
            failures++;
            $display("FAIL abort_partial_bits got=%b exp=11010", got[4:0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({clk_oe, data_oe, tx_if.o_tx_busy, tx_if.o_tx_done, tx_if.o_tx_err} !== 5'b0) begin
            failures++;
            $display("FAIL abort_async_reset got=%b exp=00000",
                     {clk_oe, data_oe, tx_if.o_tx_busy, tx_if.o_tx_done, tx_if.o_tx_err});
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        checks++;
        if ({clk_oe, data_oe, tx_if.o_tx_busy} !== 3'b0) begin
            failures++;
            $display("FAIL abort_after_release got=%b exp=000", {clk_oe, data_oe, tx_if.o_tx_busy});
        end
        test_send_byte("after_reset_f4", 8'hF4, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        logic [10:0] got;
        int hi;
        logic doe;
        int n;
        int d0;
        int e0;
        int b0;
        d0 = done_cnt;
        e0 = err_cnt;
        b0 = b2b_cnt;
        issue_req(8'h3C, 1'b1);
        wait_release(hi, doe);
        tx_if.i_tx_data = 8'hA4;
        device_clock(1'b1, 0, 0, got);
        checks++;
        if (got !== 11'b1_1_00111100_0) begin
            failures++;
            $display("FAIL b2b_first_frame got=%b exp=%b", got, 11'b1_1_00111100_0);
        end
        n = 0;
        while (!(b2b_cnt != b0 && clk_oe === 1'b1) && n < 200) begin
            cyc(1);
            n++;
        end
        tx_if.i_tx_req = 1'b0;
        checks++;
        if (b2b_cnt - b0 !== 1) begin
            failures++;
            $display("FAIL b2b_reaccept count got=%0d exp=1", b2b_cnt - b0);
        end
        wait_release(hi, doe);
        device_clock(1'b1, 0, 0, got);
        checks++;
        if (got !== 11'b1_0_10100100_0) begin
            failures++;
            $display("FAIL b2b_second_frame got=%b exp=%b", got, 11'b1_0_10100100_0);
        end
        cyc(30);
        checks++;
        if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0 || tx_if.o_tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_status done=%0d err=%0d busy=%b exp done=2 err=0 busy=0",
                     done_cnt - d0, err_cnt - e0, tx_if.o_tx_busy);
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (both_cnt !== 0 || wide_cnt !== 0) begin
            failures++;
            $display("FAIL pulse_shape overlap=%0d stretched=%0d exp 0 0", both_cnt, wide_cnt);
        end
    endtask

    initial begin
        tx_if.i_tx_data = 8'h00;
        tx_if.i_tx_req  = 1'b0;
        #2;
        test_reset();
        test_send_byte("send_ed", 8'hED, 1'b1, 0);
        test_send_byte("send_f4", 8'hF4, 1'b0, 0);
        test_timeout();
        test_ack_high();
        test_send_byte("repulse_ed", 8'hED, 1'b1, 3);
        test_reset_mid_frame();
        test_back_to_back();
        test_pulse_shape();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-length guard so a stuck DUT cannot hang the bench.
    initial begin
        #3_000_000;
        $display("FAIL global_timeout sim time exceeded limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the FPGA to an attached keyboard or mouse. It runs the PS/2 request-to-send sequence, shifts out data/parity/stop on device-generated clock edges, and checks the device ACK. It sits beside the existing PS/2 receive path on the same open-drain PS2_CLK/PS2_DATA pins; the top level builds the tri-states from the `_OE` outputs.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency
- INHIBIT_US, 100, clock-low inhibit time before the start bit
- TIMEOUT_US, 15000, maximum wait between consecutive device falling edges (and for the first one)

- CLK_50M  in  1  system clock, single clock domain
- RST_N  in  1  asynchronous, active-low reset
- PS2_CLK  in  1  raw PS/2 clock pin (asynchronous)
- PS2_DATA  in  1  raw PS/2 data pin (asynchronous)
- PS2_CLK_OE  out  1  1 = drive PS2_CLK low, 0 = release (pulled high)
- PS2_DATA_OE  out  1  1 = drive PS2_DATA low, 0 = release
- i_tx_data  in  8  byte to send, sampled on accept
- i_tx_req  in  1  send request, level; accepted only in IDLE
- o_tx_busy  out  1  high from accept until return to IDLE
- o_tx_done  out  1  one-cycle pulse: frame sent and ACK received
- o_tx_err  out  1  one-cycle pulse: timeout or missing ACK

## Operation
- PS2_CLK and PS2_DATA each pass through a 2-FF synchronizer. Falling edge is detected when the previous synchronized value is 1 and the current value is 0.
- Derived counts: INHIBIT_CYC = CLK_FREQ_HZ/1e6*INHIBIT_US (5000); TIMEOUT_CYC = CLK_FREQ_HZ/1e6*TIMEOUT_US (750000). Counter widths are sized by $clog2.
- Frame shift register (10 bits): {stop=1, parity=~^data, data[7:0]}. Bits go out LSB first. Parity is odd.
- The data pin is driven as PS2_DATA_OE = ~bit.
- FSM states:
  - IDLE: both OE = 0, busy = 0. If i_tx_req = 1, latch i_tx_data, go to INHIBIT.
  - INHIBIT: CLK_OE = 1 for INHIBIT_CYC cycles. Then go to START.
  - START: CLK_OE = 0, DATA_OE = 1 (start bit). Watchdog cleared. Go to SHIFT.
  - SHIFT: on each falling edge, present the next frame bit and increment bit_cnt (0..9). The falling edge after the stop bit has been presented goes to ACK. The stop bit is a release (DATA_OE = 0).
  - ACK: on the next falling edge, sample synchronized data. 0 → WAIT_IDLE. 1 → ERR.
  - WAIT_IDLE: wait until synchronized clock = 1 and data = 1. Then pulse o_tx_done and go to IDLE.
  - ERR: release both lines, pulse o_tx_err, go to IDLE.
- Watchdog runs in START, SHIFT, ACK and WAIT_IDLE, and resets on every falling edge. Reaching TIMEOUT_CYC goes to ERR.
- i_tx_req and i_tx_data changes while busy are ignored. A request held high after done/err starts a new frame on the next cycle.
- Asynchronous reset at any time: both OE = 0 immediately, FSM goes to IDLE, pulses are cleared, and any partial frame is abandoned.

## Timing
- Reset values: PS2_CLK_OE = 0, PS2_DATA_OE = 0, o_tx_busy = 0, o_tx_done = 0, o_tx_err = 0.
- Accept → PS2_CLK_OE = 1 on the next clock edge. It is held for exactly INHIBIT_CYC cycles.
- PS2_DATA_OE rises on the same edge that PS2_CLK_OE falls (start bit asserted as the clock is released).
- Bit update happens 3 CLK_50M cycles after a pin falling edge (2 sync + edge reg). This is well inside the ≥5 µs clock-low half period.
- o_tx_done asserts 1 cycle after both synchronized lines are high in WAIT_IDLE. o_tx_busy falls on the same cycle.
- Done and err are mutually exclusive. Each is exactly 1 cycle wide.

## Configuration
- PS2_TX_ACK_CHECK_EN defined: ACK and WAIT_IDLE states are present. A high data line at the ACK edge gives o_tx_err.
- Not defined: the falling edge after the stop bit goes straight to a done pulse and then IDLE. No ACK sampling, no wait for idle lines, and the err pulse is raised only by timeout.

## Test plan
- Device model, send 0xED → PS2_CLK_OE low for 5000 cycles; presented bits 1,0,1,1,0,1,1,1; parity 1; stop released; ACK low → one o_tx_done, busy returns to 0.
- Send 0xF4 → bits 0,0,1,0,1,1,1,1, parity 0; done pulse; no err.
- No device clock after START → o_tx_err at 750000 cycles after START; both OE = 0; FSM in IDLE.
- Device leaves data high at the ACK edge, macro defined → o_tx_err, no done. Same stimulus with macro undefined → o_tx_done.
- i_tx_req re-pulsed with 0x55 mid-frame → ignored; the original byte completes unchanged.
- RST_N low after bit 4 → both OE = 0 asynchronously, all outputs 0. After release, a new request for 0xF4 completes normally.
